// File: rtl/idx_arbiter.sv
// 16-way round-robin arbiter emitting a 4-bit grant index with a valid/ready handshake.
// Optional offer-withdrawal timeout is compiled in when RR_TIMEOUT_EN is defined.
module idx_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        idx_ready,
  output logic [3:0]  idx,
  output logic        idx_valid,
  output logic [3:0]  ptr
`ifdef RR_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t state_reg;

  logic [3:0]  next_base;
  logic [15:0] rot_ptr;
  logic [15:0] rot_next;
  logic [3:0]  off_ptr;
  logic [3:0]  off_next;
  logic [3:0]  pick_ptr;
  logic [3:0]  pick_next;
  logic        any_req;
  logic        xfer;

  assign next_base = idx + 4'd1;
  assign any_req   = |req;
  assign xfer      = idx_valid & idx_ready;

  // Rotate req so bit 0 of each vector is the search start; the 4-bit add wraps mod 16.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      logic [3:0] sel_ptr;
      logic [3:0] sel_next;
      assign sel_ptr      = ptr + 4'(gi);
      assign sel_next     = next_base + 4'(gi);
      assign rot_ptr[gi]  = req[sel_ptr];
      assign rot_next[gi] = req[sel_next];
    end
  endgenerate

  function automatic logic [3:0] first_set(input logic [15:0] v);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) pos = 4'(i);
    end
    return pos;
  endfunction

  assign off_ptr   = first_set(rot_ptr);
  assign off_next  = first_set(rot_next);
  assign pick_ptr  = ptr + off_ptr;
  assign pick_next = next_base + off_next;

`ifdef RR_TIMEOUT_EN
  logic [3:0] wait_cnt_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx          <= 4'd0;
      idx_valid    <= 1'b0;
      ptr          <= 4'd0;
`ifdef RR_TIMEOUT_EN
      wait_cnt_reg <= 4'd0;
      timeout      <= 1'b0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            idx       <= pick_ptr;
            idx_valid <= 1'b1;
            state_reg <= OFFER;
`ifdef RR_TIMEOUT_EN
            wait_cnt_reg <= 4'd0;
`endif
          end
        end
        OFFER: begin
          if (xfer) begin
            ptr <= next_base;
            // Back-to-back: rearbitrate from the just-advanced pointer on the same edge.
            if (any_req) begin
              idx <= pick_next;
`ifdef RR_TIMEOUT_EN
              wait_cnt_reg <= 4'd0;
`endif
            end else begin
              idx_valid <= 1'b0;
              state_reg <= IDLE;
            end
          end
`ifdef RR_TIMEOUT_EN
          else if (wait_cnt_reg == 4'd15) begin
            ptr       <= next_base;
            idx_valid <= 1'b0;
            state_reg <= IDLE;
            timeout   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
`endif
        end
        default: begin
          state_reg <= IDLE;
          idx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idx_arbiter.sv
// Self-checking bench for idx_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model. Define RR_TIMEOUT_EN to cover the timeout build.
module tb_idx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        idx_ready;
  logic [3:0]  idx;
  logic        idx_valid;
  logic [3:0]  ptr;
`ifdef RR_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_ptr, m_idx, m_cnt;
  bit m_valid, m_to;

  always #5 clk = ~clk;

  idx_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_valid (idx_valid),
    .ptr       (ptr)
`ifdef RR_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // First requester at or after base, walking upward with wrap; -1 if none.
  function automatic int m_pick(input logic [15:0] r, input int base);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (base + k) % 16;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_to = 0;
  endtask

  task automatic m_edge(input logic [15:0] r, input bit rdy);
    int p;
    m_to = 0;
    if (!m_valid) begin
      p = m_pick(r, m_ptr);
      if (p >= 0) begin
        m_idx = p; m_valid = 1; m_cnt = 0;
      end
    end else if (rdy) begin
      $display("xfer idx=%0d next_ptr=%0d", m_idx, (m_idx + 1) % 16);
      m_ptr = (m_idx + 1) % 16;
      p = m_pick(r, m_ptr);
      if (p >= 0) begin
        m_idx = p; m_cnt = 0;
      end else begin
        m_valid = 0;
      end
    end else begin
`ifdef RR_TIMEOUT_EN
      if (m_cnt == 15) begin
        m_ptr = (m_idx + 1) % 16; m_valid = 0; m_to = 1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic compare_model(input string tag);
    check_eq({tag, "_valid"}, 16'(idx_valid), 16'(m_valid));
    check_eq({tag, "_idx"},   16'(idx),       16'(m_idx));
    check_eq({tag, "_ptr"},   16'(ptr),       16'(m_ptr));
`ifdef RR_TIMEOUT_EN
    check_eq({tag, "_timeout"}, 16'(timeout), 16'(m_to));
`endif
  endtask

  // Drive inputs, take one edge, update the model and compare 1 time unit later.
  task automatic step(input logic [15:0] r, input bit rdy, input string tag);
    req = r;
    idx_ready = rdy;
    @(posedge clk);
    m_edge(r, rdy);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    req = 16'h0;
    idx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    compare_model("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int stall;
    logic [15:0] r;
    bit rdy;
    rst_n = 1'b0;
    req = 16'h0;
    idx_ready = 1'b0;

    // Single request, accepted, pointer moves past it
    do_reset();
    step(16'h0010, 1'b1, "single_offer");
    check_eq("single_idx", 16'(idx), 16'd4);
    step(16'h0000, 1'b1, "single_xfer");
    check_eq("single_ptr", 16'(ptr), 16'd5);
    check_eq("single_idle", 16'(idx_valid), 16'd0);

    // All requesting: 0..15,0 with no bubble
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(16'hFFFF, 1'b1, "allreq");
      check_eq("allreq_seq", 16'(idx), 16'(i % 16));
    end

    // Wrap from 15 back to 0
    do_reset();
    step(16'h0001, 1'b1, "wrap_first");
    step(16'h8001, 1'b1, "wrap_g15");
    check_eq("wrap_idx15", 16'(idx), 16'd15);
    check_eq("wrap_ptr1", 16'(ptr), 16'd1);
    step(16'h8001, 1'b1, "wrap_g0");
    check_eq("wrap_idx0", 16'(idx), 16'd0);
    check_eq("wrap_ptr0", 16'(ptr), 16'd0);

    // Offer held while stalled even after req drops
    do_reset();
    step(16'h0008, 1'b0, "hold_offer");
    for (int i = 0; i < 5; i++) begin
      step(16'h0000, 1'b0, "hold");
      check_eq("hold_idx", 16'(idx), 16'd3);
    end
    step(16'h0000, 1'b1, "hold_xfer");
    check_eq("hold_idle", 16'(idx_valid), 16'd0);
    check_eq("hold_ptr", 16'(ptr), 16'd4);

    // Asynchronous reset mid-offer
    do_reset();
    step(16'h0080, 1'b0, "arst_offer");
    check_eq("arst_idx7", 16'(idx), 16'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 16'(idx_valid), 16'd0);
    check_eq("arst_idx", 16'(idx), 16'd0);
    check_eq("arst_ptr", 16'(ptr), 16'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0000, 1'b1, "arst_after");

    // Long stall: withdrawn after 16 offer cycles only in the timeout build
    do_reset();
    step(16'h0004, 1'b0, "to_offer");
    for (int i = 1; i <= 16; i++) step(16'h0004, 1'b0, "to_wait");
`ifdef RR_TIMEOUT_EN
    check_eq("to_valid", 16'(idx_valid), 16'd0);
    check_eq("to_pulse", 16'(timeout), 16'd1);
    check_eq("to_ptr", 16'(ptr), 16'd3);
    step(16'h0000, 1'b0, "to_after");
    check_eq("to_pulse_end", 16'(timeout), 16'd0);
`else
    check_eq("nto_valid", 16'(idx_valid), 16'd1);
    check_eq("nto_idx", 16'(idx), 16'd2);
`endif

    // Randomized traffic
    do_reset();
    stall = 0;
    r = 16'h0;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0: r = 16'($urandom);
        1: r = 16'(1) << $urandom_range(0, 15);
        2: r = 16'h0;
        default: ;
      endcase
      if (stall == 0 && $urandom_range(0, 40) == 0) stall = $urandom_range(5, 25);
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      step(r, rdy, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
